// File: rtl/seg7_bcd_scanner.sv
// Binary-to-BCD converter (sequential double-dabble) driving a four-digit
// common-anode 7-segment display through a free-running digit scanner.
module seg7_bcd_scanner #(
  parameter int unsigned SCAN_DIV      = 100000,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic        masCLK,
  input  logic        Reset,
  input  logic [12:0] value,
  output logic        busy,
  output logic [15:0] bcd,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        e,
  output logic        f,
  output logic        g,
  output logic        AN0,
  output logic        AN1,
  output logic        AN2,
  output logic        AN3
);

  localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

  state_e      state_q, state_d;
  logic [12:0] last_val_q;
  logic [28:0] shreg_q;
  logic [28:0] shreg_adj;
  logic [3:0]  cnt_q;
  logic [15:0] bcd_q;

  // Converter FSM: state register
  always_ff @(posedge masCLK) begin
    if (Reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Converter FSM: next state; 13 shifts happen on counts 0..12
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (value != last_val_q) state_d = StConv;
      StConv:  if (cnt_q == 4'd12) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Converter FSM: outputs
  always_comb begin
    busy = 1'b0;
    unique case (state_q)
      StConv, StDone: busy = 1'b1;
      default:        busy = 1'b0;
    endcase
  end

  always_comb begin
    shreg_adj = shreg_q;
    for (int i = 0; i < 4; i++) begin
      if (shreg_q[13+4*i +: 4] >= 4'd5) begin
        shreg_adj[13+4*i +: 4] = shreg_q[13+4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge masCLK) begin
    if (Reset) begin
      last_val_q <= '0;
      shreg_q    <= '0;
      cnt_q      <= '0;
      bcd_q      <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (value != last_val_q) begin
            shreg_q    <= {16'b0, value};
            last_val_q <= value;
            cnt_q      <= '0;
          end
        end
        StConv: begin
          shreg_q <= {shreg_adj[27:0], 1'b0};
          cnt_q   <= cnt_q + 4'd1;
        end
        StDone:  bcd_q <= shreg_q[28:13];
        default: ;
      endcase
    end
  end

  assign bcd = bcd_q;

  // Digit scanner
  logic [DivW-1:0] div_q;
  logic [1:0]      idx_q;

  always_ff @(posedge masCLK) begin
    if (Reset) begin
      div_q <= '0;
      idx_q <= '0;
    end else if (div_q == DivW'(SCAN_DIV - 1)) begin
      div_q <= '0;
      idx_q <= idx_q + 2'd1;
    end else begin
      div_q <= div_q + DivW'(1);
    end
  end

  logic [3:0] nib;
  logic       blank;
  logic [6:0] seg_d, seg_q;
  logic [3:0] an_d, an_q;

  // A digit blanks only when it and every more significant digit are zero
  always_comb begin
    nib   = bcd_q[3:0];
    blank = 1'b0;
    unique case (idx_q)
      2'd0: nib = bcd_q[3:0];
      2'd1: begin
        nib   = bcd_q[7:4];
        blank = BLANK_LEADING && (bcd_q[15:4] == 12'd0);
      end
      2'd2: begin
        nib   = bcd_q[11:8];
        blank = BLANK_LEADING && (bcd_q[15:8] == 8'd0);
      end
      2'd3: begin
        nib   = bcd_q[15:12];
        blank = BLANK_LEADING && (bcd_q[15:12] == 4'd0);
      end
      default: ;
    endcase
  end

  always_comb begin
    unique case (nib)
      4'd0:    seg_d = 7'b0000001;
      4'd1:    seg_d = 7'b1001111;
      4'd2:    seg_d = 7'b0010010;
      4'd3:    seg_d = 7'b0000110;
      4'd4:    seg_d = 7'b1001100;
      4'd5:    seg_d = 7'b0100100;
      4'd6:    seg_d = 7'b0100000;
      4'd7:    seg_d = 7'b0001111;
      4'd8:    seg_d = 7'b0000000;
      4'd9:    seg_d = 7'b0000100;
      default: seg_d = 7'b1111111;
    endcase
    an_d = ~(4'b0001 << idx_q);
    if (blank) begin
      seg_d = 7'b1111111;
      an_d  = 4'b1111;
    end
  end

  always_ff @(posedge masCLK) begin
    if (Reset) begin
      seg_q <= 7'b0000001;
      an_q  <= 4'b1110;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign {a, b, c, d, e, f, g}  = seg_q;
  assign {AN3, AN2, AN1, AN0}   = an_q;

endmodule
